// File: rtl/mem_bus_controller.sv
// Bus-side memory/IO controller: 240-word RAM plus timer, GPIO, mailboxes and status,
// shared between the processor (always wins) and a host port served in idle cycles.
module mem_bus_controller #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_exit,
  output logic [31:0] cpu_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        host_starved,
  output logic [31:0] gpio_out
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [7:0] ADDR_TIMER  = 8'hF0;
  localparam logic [7:0] ADDR_GPIO   = 8'hF1;
  localparam logic [7:0] ADDR_C2H    = 8'hF2;
  localparam logic [7:0] ADDR_STATUS = 8'hF3;
  localparam logic [7:0] ADDR_H2C    = 8'hF4;
  localparam logic [7:0] RAM_END     = 8'hF0;

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state;
  logic [31:0]      mem [0:239];
  logic [31:0]      timer;
  logic [31:0]      c2h_data;
  logic [31:0]      h2c_data;
  logic             c2h_full;
  logic             h2c_full;
  logic             c2h_ovf;
  logic             h2c_ovf;
  logic [CNT_W-1:0] starve_cnt;

  logic        cpu_busy;
  logic        grant;
  logic        acc_wr;
  logic        cpu_read;
  logic        host_read;
  logic        c2h_wr;
  logic        h2c_wr;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] rd_data;

  // Exactly one access per cycle: the CPU when busy, otherwise a granted host.
  always_comb begin
    cpu_busy  = cpu_rd | cpu_wr;
    grant     = (state == IDLE) & host_req & ~cpu_busy;
    acc_addr  = cpu_busy ? cpu_addr : host_addr;
    acc_wdata = cpu_busy ? cpu_wdata : host_wdata;
    acc_wr    = cpu_wr | (grant & host_we);
    cpu_read  = cpu_rd & ~cpu_wr;
    host_read = grant & ~host_we;
    c2h_wr    = acc_wr & cpu_busy & (acc_addr == ADDR_C2H);
    h2c_wr    = acc_wr & ~cpu_busy & (acc_addr == ADDR_H2C);
  end

  always_comb begin
    rd_data = '0;
    if (acc_addr < RAM_END) begin
      rd_data = mem[acc_addr];
    end else begin
      case (acc_addr)
        ADDR_TIMER:  rd_data = timer;
        ADDR_GPIO:   rd_data = gpio_out;
        ADDR_C2H:    rd_data = c2h_data;
        ADDR_STATUS: rd_data = {28'd0, h2c_ovf, c2h_ovf, h2c_full, c2h_full};
        ADDR_H2C:    rd_data = h2c_data;
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && acc_wr && (acc_addr < RAM_END)) mem[acc_addr] <= acc_wdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      cpu_rdata  <= '0;
      gpio_out   <= '0;
      timer      <= '0;
      c2h_data   <= '0;
      h2c_data   <= '0;
      c2h_full   <= 1'b0;
      h2c_full   <= 1'b0;
      c2h_ovf    <= 1'b0;
      h2c_ovf    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state    <= grant ? ACK : IDLE;
      host_ack <= grant;

      if (cpu_read)  cpu_rdata  <= rd_data;
      if (host_read) host_rdata <= rd_data;

      // A timer read sees the pre-increment value because rd_data samples the register.
      if (acc_wr && (acc_addr == ADDR_TIMER)) timer <= acc_wdata;
      else if (!cpu_exit)                     timer <= timer + 32'd1;

      if (acc_wr && (acc_addr == ADDR_GPIO)) gpio_out <= acc_wdata;

      if (c2h_wr) begin
        c2h_data <= acc_wdata;
        c2h_full <= 1'b1;
        if (c2h_full) c2h_ovf <= 1'b1;
      end else if (host_read && (acc_addr == ADDR_C2H)) begin
        c2h_full <= 1'b0;
      end

      if (h2c_wr) begin
        h2c_data <= acc_wdata;
        h2c_full <= 1'b1;
        if (h2c_full) h2c_ovf <= 1'b1;
      end else if (cpu_read && (acc_addr == ADDR_H2C)) begin
        h2c_full <= 1'b0;
      end

      if (acc_wr && (acc_addr == ADDR_STATUS)) begin
        if (acc_wdata[2]) c2h_ovf <= 1'b0;
        if (acc_wdata[3]) h2c_ovf <= 1'b0;
      end

      // Counts only cycles where the host is eligible but blocked by the CPU.
      if (grant || !host_req) begin
        starve_cnt <= '0;
      end else if ((state == IDLE) && cpu_busy && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  assign host_starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model of the memory map.
module tb_mem_bus_controller;

  localparam int LIMIT = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_exit = 1'b0;
  logic [31:0] cpu_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_starved;
  logic [31:0] gpio_out;

  always #5 CLK = ~CLK;

  mem_bus_controller #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_exit(cpu_exit), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_starved(host_starved),
    .gpio_out(gpio_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        crd, cwr;
    logic [7:0]  ca;
    logic [31:0] cd;
    logic        hr, hw;
    logic [7:0]  ha;
    logic [31:0] hd;
    logic [31:0] e_crd;
    logic        e_ack;
    logic [31:0] e_hrd;
    logic [31:0] e_gpio;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(logic crd, logic cwr, logic [7:0] ca, logic [31:0] cd,
                             logic hr, logic hw, logic [7:0] ha, logic [31:0] hd,
                             logic [31:0] ec, logic ea, logic [31:0] eh, logic [31:0] eg);
    vec_t v;
    v.crd = crd; v.cwr = cwr; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.e_crd = ec; v.e_ack = ea; v.e_hrd = eh; v.e_gpio = eg;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_ram [240];
  logic [31:0] m_timer, m_gpio, m_c2h, m_h2c;
  bit          m_c2h_full, m_h2c_full, m_c2h_ovf, m_h2c_ovf;
  bit          m_in_ack;
  int          m_cnt;
  logic [31:0] e_crd, e_hrd;
  bit          e_ack;

  task automatic model_reset();
    m_timer = 0; m_gpio = 0; m_c2h = 0; m_h2c = 0;
    m_c2h_full = 0; m_h2c_full = 0; m_c2h_ovf = 0; m_h2c_ovf = 0;
    m_in_ack = 0; m_cnt = 0; e_crd = 0; e_hrd = 0; e_ack = 0;
  endtask

  // Applies the current bus inputs to the model, as the clock edge will.
  task automatic model_eval();
    bit busy, grant, is_cpu, do_wr, do_rd, twr;
    logic [7:0]  a;
    logic [31:0] d, rv;
    busy   = cpu_rd || cpu_wr;
    grant  = !m_in_ack && host_req && !busy;
    is_cpu = busy;
    a      = busy ? cpu_addr : host_addr;
    d      = busy ? cpu_wdata : host_wdata;
    do_wr  = busy ? cpu_wr : (grant && host_we);
    do_rd  = busy ? (cpu_rd && !cpu_wr) : (grant && !host_we);
    twr    = 0;
    rv     = 0;
    if (do_rd) begin
      if (a < 240) rv = m_ram[a];
      else if (a == 8'hF0) rv = m_timer;
      else if (a == 8'hF1) rv = m_gpio;
      else if (a == 8'hF2) rv = m_c2h;
      else if (a == 8'hF3) rv = {28'd0, m_h2c_ovf, m_c2h_ovf, m_h2c_full, m_c2h_full};
      else if (a == 8'hF4) rv = m_h2c;
      if (is_cpu) begin
        e_crd = rv;
        if (a == 8'hF4) m_h2c_full = 0;
      end else begin
        e_hrd = rv;
        if (a == 8'hF2) m_c2h_full = 0;
      end
    end
    if (do_wr) begin
      if (a < 240) m_ram[a] = d;
      else if (a == 8'hF0) begin m_timer = d; twr = 1; end
      else if (a == 8'hF1) m_gpio = d;
      else if (a == 8'hF2 && is_cpu) begin
        if (m_c2h_full) m_c2h_ovf = 1;
        m_c2h = d; m_c2h_full = 1;
      end else if (a == 8'hF3) begin
        if (d[2]) m_c2h_ovf = 0;
        if (d[3]) m_h2c_ovf = 0;
      end else if (a == 8'hF4 && !is_cpu) begin
        if (m_h2c_full) m_h2c_ovf = 1;
        m_h2c = d; m_h2c_full = 1;
      end
    end
    if (!twr && !cpu_exit) m_timer = m_timer + 1;
    if (grant || !host_req) m_cnt = 0;
    else if (!m_in_ack && busy && m_cnt < LIMIT) m_cnt++;
    e_ack    = grant;
    m_in_ack = grant;
  endtask

  task automatic run_cycle(input int n);
    model_eval();
    step();
    check($sformatf("rnd%0d_cpu_rdata", n), cpu_rdata, e_crd);
    check($sformatf("rnd%0d_host_rdata", n), host_rdata, e_hrd);
    check($sformatf("rnd%0d_host_ack", n), host_ack, e_ack);
    check($sformatf("rnd%0d_host_starved", n), host_starved, (m_cnt == LIMIT));
    check($sformatf("rnd%0d_gpio_out", n), gpio_out, m_gpio);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom % 2 == 0) return 8'($urandom % 240);
    return 8'hF0 + 8'($urandom % 16);
  endfunction

  localparam logic [31:0] X = 32'h12345678;

  initial begin
    logic [31:0] texp [4];
    int r;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_cpu_rdata", cpu_rdata, 0);
    check("reset_host_rdata", host_rdata, 0);
    check("reset_host_ack", host_ack, 0);
    check("reset_host_starved", host_starved, 0);
    check("reset_gpio_out", gpio_out, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    tbl.push_back(V(0,1,8'h10,X,            0,0,0,0,             0,0,0,0));
    tbl.push_back(V(1,0,8'h10,0,            0,0,0,0,             X,0,0,0));
    tbl.push_back(V(0,0,0,0,                1,0,8'h10,0,         X,1,X,0));
    tbl.push_back(V(0,1,8'hEF,32'hDEADBEEF, 0,0,0,0,             X,0,X,0));
    tbl.push_back(V(1,0,8'hEF,0,            0,0,0,0,             32'hDEADBEEF,0,X,0));
    tbl.push_back(V(0,1,8'hF2,32'hA,        0,0,0,0,             32'hDEADBEEF,0,X,0));
    tbl.push_back(V(0,1,8'hF2,32'hA,        0,0,0,0,             32'hDEADBEEF,0,X,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h5,0,X,0));
    tbl.push_back(V(0,0,0,0,                1,0,8'hF2,0,         32'h5,1,32'hA,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h4,0,32'hA,0));
    tbl.push_back(V(0,1,8'hF3,32'h4,        0,0,0,0,             32'h4,0,32'hA,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h0,0,32'hA,0));
    tbl.push_back(V(1,0,8'hF2,0,            0,0,0,0,             32'hA,0,32'hA,0));
    tbl.push_back(V(0,0,0,0,                1,1,8'hF4,32'hBEEF,  32'hA,1,32'hA,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h2,0,32'hA,0));
    tbl.push_back(V(0,0,0,0,                1,1,8'hF4,32'hCAFE,  32'h2,1,32'hA,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'hA,0,32'hA,0));
    tbl.push_back(V(0,0,0,0,                1,0,8'hF4,0,         32'hA,1,32'hCAFE,0));
    tbl.push_back(V(1,0,8'hF4,0,            0,0,0,0,             32'hCAFE,0,32'hCAFE,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h8,0,32'hCAFE,0));
    tbl.push_back(V(0,1,8'hF3,32'h8,        0,0,0,0,             32'h8,0,32'hCAFE,0));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h0,0,32'hCAFE,0));
    tbl.push_back(V(0,1,8'hF1,32'h55,       0,0,0,0,             32'h0,0,32'hCAFE,32'h55));
    tbl.push_back(V(1,1,8'hF1,32'h66,       0,0,0,0,             32'h0,0,32'hCAFE,32'h66));
    tbl.push_back(V(1,0,8'hF1,0,            0,0,0,0,             32'h66,0,32'hCAFE,32'h66));
    tbl.push_back(V(0,1,8'hF4,32'h1,        0,0,0,0,             32'h66,0,32'hCAFE,32'h66));
    tbl.push_back(V(0,1,8'hF5,32'h7,        0,0,0,0,             32'h66,0,32'hCAFE,32'h66));
    tbl.push_back(V(0,0,0,0,                1,1,8'hF2,32'h77,    32'h66,1,32'hCAFE,32'h66));
    tbl.push_back(V(1,0,8'hF3,0,            0,0,0,0,             32'h0,0,32'hCAFE,32'h66));
    tbl.push_back(V(1,0,8'hF2,0,            0,0,0,0,             32'hA,0,32'hCAFE,32'h66));
    tbl.push_back(V(1,0,8'hF4,0,            0,0,0,0,             32'hCAFE,0,32'hCAFE,32'h66));
    tbl.push_back(V(1,0,8'hF5,0,            0,0,0,0,             32'h0,0,32'hCAFE,32'h66));
    tbl.push_back(V(0,0,0,0,                1,0,8'hF1,0,         32'h0,1,32'h66,32'h66));
    tbl.push_back(V(1,0,8'h10,0,            0,0,0,0,             X,0,32'h66,32'h66));

    foreach (tbl[i]) begin
      set_cpu(tbl[i].crd, tbl[i].cwr, tbl[i].ca, tbl[i].cd);
      set_host(tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd);
      step();
      check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
      check($sformatf("vec%0d_host_ack", i), host_ack, tbl[i].e_ack);
      check($sformatf("vec%0d_host_rdata", i), host_rdata, tbl[i].e_hrd);
      check($sformatf("vec%0d_gpio_out", i), gpio_out, tbl[i].e_gpio);
    end
    set_cpu(0, 0, 0, 0);
    set_host(0, 0, 0, 0);
    step();

    // Starvation: CPU busy for 20 cycles while the host waits
    set_host(1, 0, 8'h10, 0);
    for (int i = 1; i <= 20; i++) begin
      set_cpu(1, 0, 8'h10, 0);
      step();
      check($sformatf("starve%0d_flag", i), host_starved, (i >= LIMIT));
      check($sformatf("starve%0d_ack", i), host_ack, 0);
    end
    set_cpu(0, 0, 0, 0);
    step();
    check("starve_grant_ack", host_ack, 1);
    check("starve_grant_flag", host_starved, 0);
    check("starve_grant_rdata", host_rdata, X);
    set_host(0, 0, 0, 0);
    step();
    check("starve_ack_pulse_end", host_ack, 0);

    // Timer wrap, then frozen by cpu_exit
    set_cpu(0, 1, 8'hF0, 32'hFFFF_FFFE);
    step();
    texp[0] = 32'hFFFF_FFFE; texp[1] = 32'hFFFF_FFFF; texp[2] = 32'h0; texp[3] = 32'h1;
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 0, 8'hF0, 0);
      step();
      check($sformatf("timer_wrap%0d", i), cpu_rdata, texp[i]);
    end
    cpu_exit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 0, 8'hF0, 0);
      step();
      check($sformatf("timer_frozen%0d", i), cpu_rdata, 32'h2);
    end
    cpu_exit = 1'b0;

    // Reset asserted while a host request is pending
    set_cpu(0, 1, 8'hF1, 32'h99);
    set_host(1, 0, 8'h10, 0);
    step();
    check("pre_reset_gpio", gpio_out, 32'h99);
    check("pre_reset_ack", host_ack, 0);
    set_cpu(0, 0, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    check("midreset_cpu_rdata", cpu_rdata, 0);
    check("midreset_host_rdata", host_rdata, 0);
    check("midreset_host_ack", host_ack, 0);
    check("midreset_host_starved", host_starved, 0);
    check("midreset_gpio_out", gpio_out, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("in_reset%0d_ack", i), host_ack, 0);
    end
    set_host(0, 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();

    // Randomized traffic against the model (RAM first given known contents)
    for (int a = 0; a < 240; a++) begin
      set_cpu(0, 1, 8'(a), $urandom);
      run_cycle(a);
    end
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) < 25) r = 3 + int'($urandom % 5);
      else                r = int'($urandom % 8);
      case (r)
        0, 1, 2: set_cpu(0, 0, rand_addr(), $urandom);
        3, 4:    set_cpu(1, 0, rand_addr(), $urandom);
        5, 6:    set_cpu(0, 1, rand_addr(), $urandom);
        default: set_cpu(1, 1, rand_addr(), $urandom);
      endcase
      cpu_exit = ($urandom % 16 == 0);
      run_cycle(240 + n);
      if (!host_req || host_ack) begin
        if ($urandom % 3 != 0) set_host(1, 1'($urandom % 2), rand_addr(), $urandom);
        else                   set_host(0, 0, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
